// File: rtl/stream_sink_checker.sv
// Sink-side checker for an incrementing byte stream (mod 256).
// Hunts for alignment, verifies LOCK_COUNT consecutive matches, then counts
// byte and bit errors while locked, dropping back to hunt after LOSS_COUNT
// consecutive misses. Stops accepting once NUM_BYTES bytes were checked.
module stream_sink_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int LOSS_COUNT   = 4,
    parameter int NUM_BYTES    = 64,
    parameter int STALL_PERIOD = 0
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic        valid,
    output logic        ready,
    output logic        locked,
    output logic        done,
    output logic [15:0] byte_err_cnt,
    output logic [15:0] bit_err_cnt,
    output logic [15:0] byte_cnt
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [15:0] match_q, match_d;
    logic [15:0] miss_q, miss_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] byte_err_q, byte_err_d;
    logic [15:0] bit_err_q, bit_err_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;

    logic        accept;
    logic        stall_now;
    logic [7:0]  diff;
    logic [3:0]  diff_bits;
    logic [16:0] bit_sum;

    assign accept  = valid & ready_q;
    assign diff    = data ^ exp_q;
    assign bit_sum = {1'b0, bit_err_q} + {13'b0, diff_bits};

    // Number of bits differing between the received and expected byte.
    always_comb begin
        diff_bits = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            diff_bits = diff_bits + {3'b0, diff[i]};
        end
    end

    // Next-state: sync FSM, error counters, stall pacing and completion.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        match_d    = match_q;
        miss_d     = miss_q;
        stall_d    = stall_q;
        byte_cnt_d = byte_cnt_q;
        byte_err_d = byte_err_q;
        bit_err_d  = bit_err_q;
        stall_now  = 1'b0;

        if (!done_q && accept) begin
            case (state_q)
                HUNT, VERIFY: begin
                    // HUNT and a VERIFY miss both restart the run from this byte.
                    if (state_q == VERIFY && data == exp_q) begin
                        match_d = match_q + 16'd1;
                        exp_d   = exp_q + 8'd1;
                    end else begin
                        match_d = 16'd1;
                        exp_d   = data + 8'd1;
                    end
                    if (match_d >= 16'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        state_d = VERIFY;
                    end
                end
                LOCKED: begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    exp_d      = exp_q + 8'd1;
                    if (data != exp_q) begin
                        byte_err_d = (byte_err_q == '1) ? byte_err_q : byte_err_q + 16'd1;
                        bit_err_d  = bit_sum[16] ? '1 : bit_sum[15:0];
                        miss_d     = miss_q + 16'd1;
                        if (miss_d >= 16'(LOSS_COUNT)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                            match_d = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase

            if (STALL_PERIOD > 0) begin
                stall_d = stall_q + 16'd1;
                if (stall_d >= 16'(STALL_PERIOD)) begin
                    stall_d   = '0;
                    stall_now = 1'b1;
                end
            end
        end

        done_d  = done_q | (byte_cnt_d >= 16'(NUM_BYTES));
        ready_d = !done_d && !stall_now;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= HUNT;
            exp_q      <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            stall_q    <= '0;
            byte_cnt_q <= '0;
            byte_err_q <= '0;
            bit_err_q  <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            stall_q    <= stall_d;
            byte_cnt_q <= byte_cnt_d;
            byte_err_q <= byte_err_d;
            bit_err_q  <= bit_err_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign ready        = ready_q;
    assign locked       = (state_q == LOCKED);
    assign done         = done_q;
    assign byte_cnt     = byte_cnt_q;
    assign byte_err_cnt = byte_err_q;
    assign bit_err_cnt  = bit_err_q;

endmodule

// File: doc/stream_sink_checker.md
STREAM_SINK_CHECKER -- requirements
Module: stream_sink_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 4: consecutive matching bytes needed to enter LOCKED.
REQ-002 The block SHALL have parameter LOSS_COUNT, default 4: consecutive mismatching bytes in LOCKED that force a return to HUNT.
REQ-003 The block SHALL have parameter NUM_BYTES, default 64: bytes to check in LOCKED before done.
REQ-004 The block SHALL have parameter STALL_PERIOD, default 0: ready drops for one cycle after every STALL_PERIOD accepted bytes; 0 disables stalls.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port data, input, 8 bits: the byte from the upstream source.
REQ-008 The block SHALL have port valid, input, 1 bit: data is valid.
REQ-009 The block SHALL have port ready, output, 1 bit: the sink can accept a byte.
REQ-010 The block SHALL have port locked, output, 1 bit: the FSM is in LOCKED.
REQ-011 The block SHALL have port done, output, 1 bit: NUM_BYTES bytes were checked; stays high until reset.
REQ-012 The block SHALL have port byte_err_cnt, output, 16 bits: mismatching bytes counted in LOCKED; saturates.
REQ-013 The block SHALL have port bit_err_cnt, output, 16 bits: differing bits counted in LOCKED; saturates.
REQ-014 The block SHALL have port byte_cnt, output, 16 bits: bytes checked in LOCKED.

Function
REQ-015 A byte SHALL be accepted only on a rising aclk edge where valid=1 and ready=1.
REQ-016 data SHALL be ignored on any other edge.
REQ-017 The expected stream SHALL be an incrementing byte sequence, mod 256: each byte is the previous one + 1, and 0xFF is followed by 0x00.
REQ-018 The FSM SHALL have three states: HUNT, VERIFY and LOCKED.
REQ-019 In HUNT, an accepted byte d SHALL load expected = d+1 and move the FSM to VERIFY with match_run=1.
REQ-020 In VERIFY, an accepted byte equal to expected SHALL increment match_run and expected.
REQ-021 In VERIFY, when match_run reaches LOCK_COUNT the FSM SHALL go to LOCKED on the same edge.
REQ-022 In VERIFY, an accepted byte d not equal to expected SHALL reload expected = d+1 and set match_run=1, with the FSM staying in VERIFY.
REQ-023 In LOCKED, every accepted byte SHALL increment byte_cnt and expected.
REQ-024 In LOCKED, a mismatching byte SHALL increment byte_err_cnt by 1 and bit_err_cnt by popcount(data XOR expected), in the range 1..8.
REQ-025 In LOCKED, a mismatching byte SHALL increment miss_run; a matching byte SHALL clear miss_run.
REQ-026 In LOCKED, when miss_run reaches LOSS_COUNT the FSM SHALL go to HUNT, and byte_cnt and the error counters SHALL be kept.
REQ-027 Even on a mismatch, expected SHALL advance by 1 from its old value and SHALL NOT be reloaded from data.
REQ-028 Error counters SHALL saturate at 0xFFFF and SHALL NOT wrap; bit_err_cnt SHALL clamp when an addition would overflow.
REQ-029 When byte_cnt reaches NUM_BYTES, done SHALL be 1 from the next cycle and ready SHALL be 0 from then on.
REQ-030 After done, counters SHALL freeze and the FSM SHALL hold.
REQ-031 With STALL_PERIOD=N>0, after the Nth, 2Nth, ... accepted byte ready SHALL be 0 for exactly one cycle, then return to 1.
REQ-032 The stall counter SHALL run in every state except done.
REQ-033 ready SHALL be a registered output and SHALL NOT depend combinationally on valid.
REQ-034 Upstream may hold valid=1 across a stall; the byte held through the stall SHALL be accepted on the first cycle ready=1 again, and SHALL NOT be accepted twice.
REQ-035 locked SHALL reflect the state register: 1 in the same cycle the FSM enters LOCKED, 0 in the cycle it leaves.
REQ-036 Outputs SHALL update one cycle after the accepting edge, with no further pipeline.

Reset
REQ-037 With reset=1 on a rising edge, all of the following SHALL apply on the next cycle: FSM in HUNT; ready=0; locked=0; done=0; all counters 0; match_run, miss_run and the stall counter 0.
REQ-038 On the first edge with reset=0, ready SHALL become 1, unless STALL_PERIOD logic requires 0.
REQ-039 Reset asserted mid-stream or after done SHALL override every other event on that edge.

Verification
REQ-040 Scenario, clean stream: reset 10 cycles, then drive 0x00,0x01,... with valid=1 continuously; required response is locked=1 right after byte 0x03 is accepted, done after 64 more bytes, byte_cnt=64, both error counts 0, then ready=0.
REQ-041 Scenario, single corrupt byte in LOCKED: expected 0x20 replaced by 0x2F; required response is byte_err_cnt=1, bit_err_cnt=4, locked stays 1, and the next byte 0x21 matches.
REQ-042 Scenario, sequence jump: four consecutive wrong bytes in LOCKED, then a jump to 0x80,0x81,...; required response is return to HUNT after the 4th miss (byte_err_cnt=4), relock after 4 bytes from 0x80, and byte_cnt keeps counting.
REQ-043 Scenario, wrap-around: stream 0xFD..0x05; required response is no error at the 0xFF->0x00 step.
REQ-044 Scenario, backpressure: STALL_PERIOD=3 with valid held at 1; required response is ready low one cycle after every 3rd accept, no byte duplicated or dropped, and zero errors.
REQ-045 Scenario, reset mid-stream: reset=1 for one cycle after 10 bytes in LOCKED; required response is all outputs cleared next cycle and relock on the following 4 good bytes.
